// File: rtl/fpu_bus_master.sv
// fpu_bus_master
// Hardware initiator for the FPU 8-bit peripheral bus. Accepts one operation
// request (A, B, op) on a valid/ready interface and runs the full register
// sequence: operand writes, op write, start write, wait for cmd_end, result
// read, end_ack handshake, then emits a one-cycle response.
//
// Ports:
//   clk, arst           clock, synchronous active-high reset
//   req_*               request interface (valid/ready, op, operands, use_b)
//   rsp_*               response pulse, result word, timeout flag
//   fpu_data_out/in     FPU data bus (write / read)
//   fpu_addr            FPU register address
//   fpu_cs/rd/wr        active-low chip select and strobes
//   fpu_end_ack         end acknowledge (active-high)
//   fpu_cmd_end         command end level from the FPU
//   fpu_busy            FPU busy, gates request acceptance
module fpu_bus_master #(
    parameter int unsigned STROBE_CYCLES  = 1,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic        clk,
    input  logic        arst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [7:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic        req_use_b,
    output logic        rsp_valid,
    output logic [31:0] rsp_result,
    output logic        rsp_timeout,
    output logic [7:0]  fpu_data_out,
    input  logic [7:0]  fpu_data_in,
    output logic [3:0]  fpu_addr,
    output logic        fpu_cs,
    output logic        fpu_rd,
    output logic        fpu_wr,
    output logic        fpu_end_ack,
    input  logic        fpu_cmd_end,
    input  logic        fpu_busy
);

    localparam int unsigned SW = (STROBE_CYCLES > 1) ? $clog2(STROBE_CYCLES) : 1;
    localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [3:0] {
        StIdle,
        StWrA,
        StWrB,
        StWrOp,
        StWrStart,
        StWaitEnd,
        StRdRes,
        StAck,
        StDone
    } state_e;

    // Sub-phases of one bus access.
    typedef enum logic [1:0] {
        PhSetup,
        PhStrobe,
        PhHold
    } phase_e;

    function automatic logic is_access(state_e s);
        return (s == StWrA) || (s == StWrB) || (s == StWrOp) || (s == StWrStart) ||
               (s == StRdRes);
    endfunction

    function automatic logic is_write(state_e s);
        return (s == StWrA) || (s == StWrB) || (s == StWrOp) || (s == StWrStart);
    endfunction

    state_e        state_q, state_d;
    phase_e        phase_q, phase_d;
    logic [SW-1:0] scnt_q, scnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          tmo_hit_q, tmo_hit_d;
    logic [31:0]   a_q, a_d;
    logic [31:0]   b_q, b_d;
    logic [7:0]    op_q, op_d;
    logic          use_b_q, use_b_d;
    logic [31:0]   res_q, res_d;

    logic          cs_q, cs_d;
    logic          rd_q, rd_d;
    logic          wr_q, wr_d;
    logic [3:0]    addr_q, addr_d;
    logic [7:0]    dout_q, dout_d;
    logic          end_ack_q, end_ack_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [31:0]   rsp_result_q, rsp_result_d;
    logic          rsp_timeout_q, rsp_timeout_d;

    logic          access_done;
    logic          strobe_last;
    logic          tmo_expired;

    assign req_ready   = (state_q == StIdle) && !fpu_busy;
    assign strobe_last = (scnt_q == SW'(STROBE_CYCLES - 1));
    // Counter is cleared on entry, so hitting TIMEOUT_CYCLES-1 means the
    // state has been occupied for TIMEOUT_CYCLES cycles.
    assign tmo_expired = (TIMEOUT_CYCLES != 0) && (tmo_q == TW'(TIMEOUT_CYCLES - 1));

    // Sequencer next state.
    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        scnt_d      = scnt_q;
        idx_d       = idx_q;
        tmo_d       = tmo_q;
        tmo_hit_d   = tmo_hit_q;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        use_b_d     = use_b_q;
        res_d       = res_q;
        access_done = 1'b0;

        if (is_access(state_q)) begin
            unique case (phase_q)
                PhSetup: begin
                    phase_d = PhStrobe;
                    scnt_d  = '0;
                end
                PhStrobe: begin
                    if (strobe_last) begin
                        phase_d = PhHold;
                        // Capture on the edge that ends the strobe.
                        if (state_q == StRdRes) begin
                            res_d[{idx_q, 3'b000} +: 8] = fpu_data_in;
                        end
                    end else begin
                        scnt_d = scnt_q + 1'b1;
                    end
                end
                PhHold: begin
                    access_done = 1'b1;
                    phase_d     = PhSetup;
                end
                default: phase_d = PhSetup;
            endcase
        end

        unique case (state_q)
            StIdle: begin
                if (req_valid && req_ready) begin
                    a_d       = req_a;
                    b_d       = req_b;
                    op_d      = req_op;
                    use_b_d   = req_use_b;
                    idx_d     = 2'd0;
                    phase_d   = PhSetup;
                    tmo_hit_d = 1'b0;
                    state_d   = StWrA;
                end
            end
            StWrA: begin
                if (access_done) begin
                    if (idx_q == 2'd3) begin
                        idx_d   = 2'd0;
                        state_d = use_b_q ? StWrB : StWrOp;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end
            StWrB: begin
                if (access_done) begin
                    if (idx_q == 2'd3) begin
                        idx_d   = 2'd0;
                        state_d = StWrOp;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end
            StWrOp: begin
                if (access_done) begin
                    state_d = StWrStart;
                end
            end
            StWrStart: begin
                if (access_done) begin
                    tmo_d   = '0;
                    state_d = StWaitEnd;
                end
            end
            StWaitEnd: begin
                if (fpu_cmd_end) begin
                    idx_d   = 2'd0;
                    phase_d = PhSetup;
                    state_d = StRdRes;
                end else if (tmo_expired) begin
                    tmo_hit_d = 1'b1;
                    state_d   = StDone;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            StRdRes: begin
                if (access_done) begin
                    if (idx_q == 2'd3) begin
                        idx_d   = 2'd0;
                        tmo_d   = '0;
                        state_d = StAck;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end
            StAck: begin
                if (!fpu_cmd_end) begin
                    state_d = StDone;
                end else if (tmo_expired) begin
                    tmo_hit_d = 1'b1;
                    state_d   = StDone;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs are decoded from the next state so they register together
    // with it; the cycle after an edge always shows that edge's state.
    always_comb begin
        cs_d          = 1'b1;
        rd_d          = 1'b1;
        wr_d          = 1'b1;
        addr_d        = 4'd0;
        dout_d        = 8'd0;
        end_ack_d     = 1'b0;
        rsp_valid_d   = 1'b0;
        rsp_result_d  = rsp_result_q;
        rsp_timeout_d = rsp_timeout_q;

        unique case (state_d)
            StWrA: begin
                cs_d   = 1'b0;
                addr_d = {2'b00, idx_d};
                dout_d = a_d[{idx_d, 3'b000} +: 8];
            end
            StWrB: begin
                cs_d   = 1'b0;
                addr_d = {2'b01, idx_d};
                dout_d = b_d[{idx_d, 3'b000} +: 8];
            end
            StWrOp: begin
                cs_d   = 1'b0;
                addr_d = 4'd8;
                dout_d = op_d;
            end
            StWrStart: begin
                cs_d   = 1'b0;
                addr_d = 4'd9;
            end
            StRdRes: begin
                cs_d   = 1'b0;
                addr_d = 4'd9 + {2'b00, idx_d};
            end
            StAck: end_ack_d = 1'b1;
            StDone: begin
                rsp_valid_d   = 1'b1;
                rsp_result_d  = tmo_hit_d ? 32'd0 : res_d;
                rsp_timeout_d = tmo_hit_d;
            end
            default: ;
        endcase

        if (phase_d == PhStrobe) begin
            if (is_write(state_d)) begin
                wr_d = 1'b0;
            end else if (state_d == StRdRes) begin
                rd_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (arst) begin
            state_q       <= StIdle;
            phase_q       <= PhSetup;
            scnt_q        <= '0;
            idx_q         <= 2'd0;
            tmo_q         <= '0;
            tmo_hit_q     <= 1'b0;
            a_q           <= 32'd0;
            b_q           <= 32'd0;
            op_q          <= 8'd0;
            use_b_q       <= 1'b0;
            res_q         <= 32'd0;
            cs_q          <= 1'b1;
            rd_q          <= 1'b1;
            wr_q          <= 1'b1;
            addr_q        <= 4'd0;
            dout_q        <= 8'd0;
            end_ack_q     <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_result_q  <= 32'd0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            phase_q       <= phase_d;
            scnt_q        <= scnt_d;
            idx_q         <= idx_d;
            tmo_q         <= tmo_d;
            tmo_hit_q     <= tmo_hit_d;
            a_q           <= a_d;
            b_q           <= b_d;
            op_q          <= op_d;
            use_b_q       <= use_b_d;
            res_q         <= res_d;
            cs_q          <= cs_d;
            rd_q          <= rd_d;
            wr_q          <= wr_d;
            addr_q        <= addr_d;
            dout_q        <= dout_d;
            end_ack_q     <= end_ack_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_result_q  <= rsp_result_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign fpu_cs       = cs_q;
    assign fpu_rd       = rd_q;
    assign fpu_wr       = wr_q;
    assign fpu_addr     = addr_q;
    assign fpu_data_out = dout_q;
    assign fpu_end_ack  = end_ack_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_result   = rsp_result_q;
    assign rsp_timeout  = rsp_timeout_q;

endmodule

// File: doc/fpu_bus_master.md
Name: fpu_bus_master

Overview:
Hardware initiator for the FPU's 8-bit peripheral bus. It accepts one 32-bit operation request (operands plus op code) on a valid/ready interface and performs the byte-serial register sequence itself: operand writes, op write, start write, wait for cmd_end, result read, end_ack handshake. It sits between a CPU-side sequencer or microcode unit and the fpu block, so software no longer bit-bangs the FPU.

Parameters:
STROBE_CYCLES, 1, clock cycles rd/wr is held low per access (≥1)
TIMEOUT_CYCLES, 4096, max cycles spent in WAIT_END or ACK before aborting; 0 disables timeout

Ports:
clk  in  1  system clock, all logic on rising edge
arst  in  1  reset, synchronous, active-high
req_valid  in  1  request present
req_ready  out  1  request accepted when req_valid & req_ready at clk edge
req_op  in  8  operation code (pa_fpu::e_fpu_operations encoding)
req_a  in  32  operand A
req_b  in  32  operand B
req_use_b  in  1  1 = write operand B; 0 = unary op, B registers untouched
rsp_valid  out  1  one-cycle pulse: response fields valid
rsp_result  out  32  result word, held until next rsp_valid
rsp_timeout  out  1  valid with rsp_valid; 1 = aborted, rsp_result = 0
fpu_data_out  out  8  write data to FPU databus_in
fpu_data_in  in  8  read data from FPU databus_out
fpu_addr  out  4  register address
fpu_cs  out  1  chip select, active-low
fpu_rd  out  1  read strobe, active-low
fpu_wr  out  1  write strobe, active-low
fpu_end_ack  out  1  end acknowledge, active-high
fpu_cmd_end  in  1  command end, active-high level
fpu_busy  in  1  FPU operation in progress

Behaviour:
- Register map: 0-3 A bytes [7:0]..[31:24]; 4-7 B bytes; 8 op; write 9 = start; read 9,A,B,C = result bytes [7:0]..[31:24].
- All bus outputs registered. Reset/idle values: fpu_cs=1, fpu_rd=1, fpu_wr=1, fpu_end_ack=0, fpu_addr=0, fpu_data_out=0, rsp_valid=0, rsp_timeout=0, rsp_result=0.
- req_ready = (state==IDLE) & !fpu_busy (combinational). Request fields latched on acceptance.
- Access = SETUP (1 cycle: cs=0, addr/data driven, strobe high) → STROBE (STROBE_CYCLES: cs=0, rd or wr=0) → HOLD (1 cycle: cs=0, strobe high, addr/data held) → cs=1 next cycle unless the following access begins. Access length = STROBE_CYCLES+2; back-to-back accesses keep cs=0 continuously.
- Read data captured from fpu_data_in on the clk edge ending the last STROBE cycle.
- States: IDLE → WR_A (4 accesses) → WR_B (4, skipped if !req_use_b) → WR_OP (1) → WR_START (1) → WAIT_END → RD_RES (4) → ACK → DONE → IDLE.
- WAIT_END: bus idle; leave when fpu_cmd_end sampled 1.
- ACK: fpu_end_ack=1; on fpu_cmd_end sampled 0 → DONE (end_ack=0 in DONE).
- DONE: rsp_valid=1 for exactly one cycle; rsp_result = assembled word; → IDLE. New request acceptable the cycle after DONE.
- Timeout: counter cleared on entry to WAIT_END and ACK; reaching TIMEOUT_CYCLES → DONE with rsp_timeout=1, rsp_result=0, no further bus accesses, end_ack dropped.
- Write phase duration: (10 or 6)×(STROBE_CYCLES+2) cycles from acceptance edge.
- Reset mid-operation: next edge returns all outputs to idle values, state IDLE, no rsp_valid, partial result discarded.
- fpu_cmd_end already 1 on WAIT_END entry: proceed immediately to RD_RES.
- fpu_busy is checked only in IDLE.

Test Plan:
1. req_a=0x40490FDA, req_b=0x402DF854, req_op=0x01, use_b=1; FPU model asserts cmd_end 20 cycles after start, result 0x447BC7BE → write trace addr0..7 = DA,0F,49,40,54,F8,2D,40, addr8=01, addr9 write; reads 9..C; rsp_result=0x447BC7BE, rsp_timeout=0; end_ack high until cmd_end low.
2. Unary: req_a=0x3EE839F1, op=op_sqrt, use_b=0, model result 0x3F2C68D4 → exactly 6 write strobes, no access to addr 4-7, rsp_result=0x3F2C68D4.
3. TIMEOUT_CYCLES=64, model never asserts cmd_end → rsp_valid exactly 64 cycles after WAIT_END entry, rsp_timeout=1, rsp_result=0, no rd strobe, end_ack never 1.
4. fpu_busy=1 with req_valid=1 for 10 cycles → req_ready=0, fpu_cs stays 1; drop busy → accepted next edge, SETUP the cycle after.
5. arst pulsed during WR_B strobe → next edge cs=rd=wr=1, end_ack=0, no rsp_valid; subsequent request completes full sequence correctly.
6. STROBE_CYCLES=3, back-to-back requests (req_valid held) → every wr/rd low exactly 3 cycles with cs low one cycle before and after; second request accepted the cycle after the first rsp_valid.
